melody_sequencer: RTL and testbench

Parametrised, multi-channel, RAM-programmed melody player that generalises the fixed single-tune music box. Each channel steps through its own score of note entries (frequency plus duration in ticks). A shared tick generator times all channels, and the block adds start/stop/pause/loop control. The per-channel frequency words feed the tone generators directly; the bus host loads scores through a write port while the block is idle.

---
 rtl/musicbox_pkg.sv | 23 ++
 rtl/melody_channel.sv | 111 +++++++++++
 rtl/melody_sequencer.sv | 114 +++++++++++
 tb/tb_melody_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/musicbox_pkg.sv
// Shared types and constants for the melody sequencer: the global playback
// state, default field widths and a few handy note frequencies in Hz.
package musicbox_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    PAUSED = 2'd2
  } state_t;

  localparam int DEF_FREQ_W = 11;
  localparam int DEF_DUR_W  = 4;

  localparam int NOTE_D4  = 294;
  localparam int NOTE_E4  = 330;
  localparam int NOTE_F4  = 349;
  localparam int NOTE_G4  = 392;
  localparam int NOTE_A4  = 440;
  localparam int NOTE_BB4 = 466;
  localparam int NOTE_C5  = 523;
  localparam int NOTE_D5  = 587;

endpackage

// File: rtl/melody_channel.sv
// One playback channel: its own score RAM plus the pointer, remaining-tick
// count, current note and ended flag. The next note value is exported so the
// top level can register the gated output frequency without an extra cycle.
module melody_channel
  import musicbox_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int FREQ_W = DEF_FREQ_W,
  parameter int DUR_W  = DEF_DUR_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [FREQ_W-1:0]        wr_freq,
  input  logic [DUR_W-1:0]         wr_dur,
  input  logic                     load,
  input  logic                     tick,
  output logic [FREQ_W-1:0]        note_nxt,
  output logic                     end_on_tick,
  output logic                     note_strobe
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [FREQ_W-1:0] freq_mem [DEPTH];
  logic [DUR_W-1:0]  dur_mem  [DEPTH];

  logic [AW-1:0]     ptr;
  logic [AW-1:0]     ptr_nxt;
  logic [AW-1:0]     next_addr;
  logic [DUR_W-1:0]  rem;
  logic [DUR_W-1:0]  rem_nxt;
  logic [FREQ_W-1:0] note;
  logic              ended;
  logic              ended_nxt;
  logic              strobe_nxt;
  logic              at_last;

  // The entry after the current one; the last slot has no successor.
  assign next_addr = (ptr == LAST_ADDR) ? ptr : ptr + AW'(1);
  assign at_last   = (ptr == LAST_ADDR) || (dur_mem[next_addr] == '0);

  // True when this channel will be ended after a tick in this cycle; it does
  // not depend on load/tick so the song-end decision has no feedback path.
  assign end_on_tick = ended || ((rem <= DUR_W'(1)) && at_last);

  // Score RAM: written by the host only; deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      freq_mem[wr_addr] <= wr_freq;
      dur_mem[wr_addr]  <= wr_dur;
    end
  end

  // Next-state of the channel: a load restarts from entry 0, a tick counts
  // down the current note and steps to the following entry when it expires.
  always_comb begin
    ptr_nxt    = ptr;
    rem_nxt    = rem;
    note_nxt   = note;
    ended_nxt  = ended;
    strobe_nxt = 1'b0;
    if (load) begin
      ptr_nxt    = '0;
      strobe_nxt = 1'b1;
      if (dur_mem[0] == '0) begin
        ended_nxt = 1'b1;
        note_nxt  = '0;
        rem_nxt   = '0;
      end else begin
        ended_nxt = 1'b0;
        note_nxt  = freq_mem[0];
        rem_nxt   = dur_mem[0];
      end
    end else if (tick && !ended) begin
      if (rem > DUR_W'(1)) begin
        rem_nxt = rem - DUR_W'(1);
      end else if (at_last) begin
        ptr_nxt   = next_addr;
        ended_nxt = 1'b1;
        note_nxt  = '0;
        rem_nxt   = '0;
      end else begin
        ptr_nxt    = next_addr;
        rem_nxt    = dur_mem[next_addr];
        note_nxt   = freq_mem[next_addr];
        strobe_nxt = 1'b1;
      end
    end
  end

  // Channel registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr         <= '0;
      rem         <= '0;
      note        <= '0;
      ended       <= 1'b1;
      note_strobe <= 1'b0;
    end else begin
      ptr         <= ptr_nxt;
      rem         <= rem_nxt;
      note        <= note_nxt;
      ended       <= ended_nxt;
      note_strobe <= strobe_nxt;
    end
  end

endmodule

// File: rtl/melody_sequencer.sv
// Multi-channel melody player: global IDLE/PLAY/PAUSED control, the shared
// duration tick counter and song-end handling around NUM_CH channels.
module melody_sequencer
  import musicbox_pkg::*;
#(
  parameter int TICK_CYCLES = 12_500_000,
  parameter int NUM_CH      = 2,
  parameter int DEPTH       = 64,
  parameter int FREQ_W      = DEF_FREQ_W,
  parameter int DUR_W       = DEF_DUR_W
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      pause,
  input  logic                      loop,
  input  logic                      wr_en,
  input  logic [$clog2(NUM_CH)-1:0] wr_ch,
  input  logic [$clog2(DEPTH)-1:0]  wr_addr,
  input  logic [FREQ_W-1:0]         wr_freq,
  input  logic [DUR_W-1:0]          wr_dur,
  output logic [NUM_CH*FREQ_W-1:0]  freq,
  output logic [NUM_CH-1:0]         note_strobe,
  output logic                      busy,
  output logic                      done
);

  localparam int CW    = $clog2(NUM_CH);
  localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

  state_t                   state;
  state_t                   state_nxt;
  logic [CNT_W-1:0]         cnt;
  logic                     tick_hit;
  logic                     tick;
  logic                     song_end;
  logic                     ch_load;
  logic                     start_acc;
  logic                     wr_ok;
  logic [NUM_CH-1:0]        end_vec;
  logic [NUM_CH*FREQ_W-1:0] note_nxt;

  // Stop beats start; a tick coinciding with start or stop is discarded.
  assign start_acc = start && !stop;
  assign tick_hit  = (state == PLAY) && (cnt == CNT_W'(TICK_CYCLES - 1));
  assign tick      = tick_hit && !stop && !start;
  assign song_end  = tick && (&end_vec);
  assign ch_load   = start_acc || (song_end && loop);
  assign wr_ok     = wr_en && (state == IDLE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    melody_channel #(
      .DEPTH  (DEPTH),
      .FREQ_W (FREQ_W),
      .DUR_W  (DUR_W)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_ok && (wr_ch == CW'(c))),
      .wr_addr     (wr_addr),
      .wr_freq     (wr_freq),
      .wr_dur      (wr_dur),
      .load        (ch_load),
      .tick        (tick),
      .note_nxt    (note_nxt[c*FREQ_W +: FREQ_W]),
      .end_on_tick (end_vec[c]),
      .note_strobe (note_strobe[c])
    );
  end

  // Next global state with stop > start > song end > pause priority.
  always_comb begin
    state_nxt = state;
    if (stop) begin
      state_nxt = IDLE;
    end else if (start) begin
      state_nxt = PLAY;
    end else begin
      case (state)
        PLAY: begin
          if (song_end && !loop) state_nxt = IDLE;
          else if (pause)        state_nxt = PAUSED;
          else                   state_nxt = PLAY;
        end
        PAUSED:  state_nxt = pause ? PAUSED : PLAY;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM, tick counter and registered outputs; freq follows the next note
  // only while the block will be playing, so pause/stop silence it at once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      freq  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start || stop) begin
        cnt <= '0;
      end else if (state == PLAY) begin
        cnt <= tick_hit ? '0 : cnt + CNT_W'(1);
      end
      freq <= (state_nxt == PLAY) ? note_nxt : '0;
      busy <= (state_nxt != IDLE);
      done <= song_end && !loop;
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed, table-driven bench for melody_sequencer with a 4-cycle tick.
module tb_melody_sequencer;
  import musicbox_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        pause = 1'b0;
  logic        loop = 1'b0;
  logic        wr_en = 1'b0;
  logic [0:0]  wr_ch = '0;
  logic [5:0]  wr_addr = '0;
  logic [10:0] wr_freq = '0;
  logic [3:0]  wr_dur = '0;
  logic [21:0] freq;
  logic [1:0]  note_strobe;
  logic        busy;
  logic        done;

  int n_vec = 0;
  int n_fail = 0;

  typedef struct {
    logic        start;
    logic        stop;
    logic        pause;
    logic        loop;
    logic [10:0] f0;
    logic [10:0] f1;
    logic        stb0;
    logic        stb_dc;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  melody_sequencer #(
    .TICK_CYCLES (4),
    .NUM_CH      (2),
    .DEPTH       (64),
    .FREQ_W      (11),
    .DUR_W       (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .pause       (pause),
    .loop        (loop),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_addr     (wr_addr),
    .wr_freq     (wr_freq),
    .wr_dur      (wr_dur),
    .freq        (freq),
    .note_strobe (note_strobe),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start = v.start;
    stop  = v.stop;
    pause = v.pause;
    loop  = v.loop;
  endtask

  task automatic addRun(input int n, input int st, input int sp, input int pa, input int lp,
                        input int f0, input int f1, input int stb0, input int dc,
                        input int bz, input int dn);
    for (int i = 0; i < n; i++) begin
      vecs.push_back('{1'(st), 1'(sp), 1'(pa), 1'(lp), 11'(f0), 11'(f1),
                       1'(stb0), 1'(dc), 1'(bz), 1'(dn)});
    end
  endtask

  task automatic runTable(input string name);
    foreach (vecs[i]) begin
      logic stb_act;
      stb_act = vecs[i].stb_dc ? vecs[i].stb0 : note_strobe[0];
      checkOutput($sformatf("%s[%0d] {f0,f1,stb0,busy,done}", name, i),
                  {7'd0, freq[10:0], freq[21:11], stb_act, busy, done},
                  {7'd0, vecs[i].f0, vecs[i].f1, vecs[i].stb0, vecs[i].busy, vecs[i].done});
      applyStimulus(vecs[i]);
      stepCycle();
    end
    vecs.delete();
    start = 1'b0;
    stop  = 1'b0;
    pause = 1'b0;
    loop  = 1'b0;
  endtask

  task automatic writeEntry(input int ch, input int addr, input int f, input int d);
    wr_en   = 1'b1;
    wr_ch   = 1'(ch);
    wr_addr = 6'(addr);
    wr_freq = 11'(f);
    wr_dur  = 4'(d);
    stepCycle();
    wr_en   = 1'b0;
  endtask

  task automatic loadSong1();
    writeEntry(0, 0, NOTE_F4, 2);
    writeEntry(0, 1, NOTE_E4, 1);
    writeEntry(0, 2, 0, 0);
    writeEntry(1, 0, 0, 0);
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("reset_freq", 32'(freq), 32'd0);
    checkOutput("reset_strobe", 32'(note_strobe), 32'd0);
    checkOutput("reset_busy_done", {30'd0, busy, done}, 32'd0);
    reset = 1'b1;
    stepCycle();

    // Song 1: 349 for 2 ticks, 330 for 1 tick, then done
    loadSong1();
    addRun(1, 1,0,0,0, 0,0,       0,0, 0,0);
    addRun(1, 0,0,0,0, NOTE_F4,0, 1,0, 1,0);
    addRun(7, 0,0,0,0, NOTE_F4,0, 0,0, 1,0);
    addRun(1, 0,0,0,0, NOTE_E4,0, 1,0, 1,0);
    addRun(3, 0,0,0,0, NOTE_E4,0, 0,0, 1,0);
    addRun(1, 0,0,0,0, 0,0,       0,1, 0,1);
    addRun(1, 0,0,0,0, 0,0,       0,0, 0,0);
    runTable("song1");

    // Two channels of different lengths, single done at the end
    writeEntry(0, 0, NOTE_F4, 3);
    writeEntry(0, 1, 0, 0);
    writeEntry(1, 0, NOTE_A4, 1);
    writeEntry(1, 1, 0, 0);
    addRun(1, 1,0,0,0, 0,0,             0,0, 0,0);
    addRun(1, 0,0,0,0, NOTE_F4,NOTE_A4, 1,0, 1,0);
    addRun(3, 0,0,0,0, NOTE_F4,NOTE_A4, 0,0, 1,0);
    addRun(8, 0,0,0,0, NOTE_F4,0,       0,0, 1,0);
    addRun(1, 0,0,0,0, 0,0,             0,1, 0,1);
    addRun(1, 0,0,0,0, 0,0,             0,0, 0,0);
    runTable("two_ch");

    // Looping: seamless second pass, then loop cleared ends the song
    loadSong1();
    addRun(1,  1,0,0,1, 0,0,       0,0, 0,0);
    addRun(1,  0,0,0,1, NOTE_F4,0, 1,0, 1,0);
    addRun(7,  0,0,0,1, NOTE_F4,0, 0,0, 1,0);
    addRun(1,  0,0,0,1, NOTE_E4,0, 1,0, 1,0);
    addRun(3,  0,0,0,1, NOTE_E4,0, 0,0, 1,0);
    addRun(1,  0,0,0,0, NOTE_F4,0, 1,0, 1,0);
    addRun(7,  0,0,0,0, NOTE_F4,0, 0,0, 1,0);
    addRun(1,  0,0,0,0, NOTE_E4,0, 1,0, 1,0);
    addRun(3,  0,0,0,0, NOTE_E4,0, 0,0, 1,0);
    addRun(1,  0,0,0,0, 0,0,       0,1, 0,1);
    addRun(1,  0,0,0,0, 0,0,       0,0, 0,0);
    runTable("loop");

    // Pause for 10 cycles starting at t+3; paused cycles do not count
    addRun(1, 1,0,0,0, 0,0,       0,0, 0,0);
    addRun(1, 0,0,0,0, NOTE_F4,0, 1,0, 1,0);
    addRun(1, 0,0,0,0, NOTE_F4,0, 0,0, 1,0);
    addRun(1, 0,0,1,0, NOTE_F4,0, 0,0, 1,0);
    addRun(9, 0,0,1,0, 0,0,       0,0, 1,0);
    addRun(1, 0,0,0,0, 0,0,       0,0, 1,0);
    addRun(5, 0,0,0,0, NOTE_F4,0, 0,0, 1,0);
    addRun(1, 0,0,0,0, NOTE_E4,0, 1,0, 1,0);
    addRun(3, 0,0,0,0, NOTE_E4,0, 0,0, 1,0);
    addRun(1, 0,0,0,0, 0,0,       0,1, 0,1);
    addRun(1, 0,0,0,0, 0,0,       0,0, 0,0);
    runTable("pause");

    // Stop mid-note: silent and idle next cycle, no done
    addRun(1, 1,0,0,0, 0,0,       0,0, 0,0);
    addRun(1, 0,0,0,0, NOTE_F4,0, 1,0, 1,0);
    addRun(1, 0,0,0,0, NOTE_F4,0, 0,0, 1,0);
    addRun(1, 0,1,0,0, NOTE_F4,0, 0,0, 1,0);
    addRun(2, 0,0,0,0, 0,0,       0,0, 0,0);
    runTable("stop");

    // Score write during PLAY is ignored
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    stepCycle();
    writeEntry(0, 0, NOTE_C5, 2);
    stop = 1'b1;
    stepCycle();
    stop = 1'b0;
    stepCycle();
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput("write_ignored_freq0", 32'(freq[10:0]), 32'(NOTE_F4));
    checkOutput("write_ignored_busy", 32'(busy), 32'd1);

    // start and stop together while playing: stop wins
    stepCycle();
    start = 1'b1;
    stop  = 1'b1;
    stepCycle();
    start = 1'b0;
    stop  = 1'b0;
    checkOutput("start_stop_busy", 32'(busy), 32'd0);
    checkOutput("start_stop_freq", 32'(freq), 32'd0);
    checkOutput("start_stop_strobe", 32'(note_strobe), 32'd0);

    // Reset mid-note, then restart from the retained score
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("pre_reset_freq0", 32'(freq[10:0]), 32'(NOTE_F4));
    reset = 1'b0;
    stepCycle();
    reset = 1'b1;
    checkOutput("mid_reset_freq", 32'(freq), 32'd0);
    checkOutput("mid_reset_busy", 32'(busy), 32'd0);
    start = 1'b1;
    stepCycle();
    start = 1'b0;
    checkOutput("restart_freq0", 32'(freq[10:0]), 32'(NOTE_F4));
    checkOutput("restart_strobe0", 32'(note_strobe[0]), 32'd1);
    stepCycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
